// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and its I-cache.
// Holds control constants, bus ranges, stall-vector layout and FSM states.
package if_fetch_pkg;

    localparam logic        rstEnable = 1'b1;
    localparam logic        Jump      = 1'b1;
    localparam logic        Stall     = 1'b1;
    localparam logic        NoStall   = 1'b0;
    localparam logic        Enable    = 1'b1;
    localparam logic        Disable   = 1'b0;
    localparam logic [31:0] ZERO32    = 32'h0000_0000;

    // Stall vector layout; the fetch stage obeys one bit of it.
    localparam int StallWidth = 6;
    localparam int StallIfBit = 1;

    // Address and instruction bus ranges.
    localparam int InstAddrMsb = 31;
    localparam int InstMsb     = 31;
    localparam int InstAddrW   = InstAddrMsb + 1;
    localparam int InstW       = InstMsb + 1;

    // Word stride between sequential instructions.
    localparam int PcStep = 4;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_WAIT = 2'b01,
        IF_HOLD = 2'b10
    } if_state_e;

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped instruction cache, one word per line, used by if_fetch.
// Ports: clk_i/rst_i (async, active-high); lookup lkAddr_i -> hit_o,
// lkData_o (combinational); fill we_i, wrAddr_i, wrData_i (registered).
module if_fetch_icache
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = InstAddrW,
    parameter int INST_W = InstW,
    parameter int LINES  = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] lkAddr_i,
    output logic              hit_o,
    output logic [INST_W-1:0] lkData_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [INST_W-1:0] wrData_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [INST_W-1:0] data_q [LINES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;

    assign lk_idx = lkAddr_i[IDX_W+1:2];
    assign lk_tag = lkAddr_i[ADDR_W-1:IDX_W+2];
    assign wr_idx = wrAddr_i[IDX_W+1:2];
    assign wr_tag = wrAddr_i[ADDR_W-1:IDX_W+2];

    // Only the valid bits need a reset; tag/data are qualified by them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i == rstEnable) begin
            valid_q <= '0;
        end else if (we_i == Enable) begin
            valid_q[wr_idx] <= Enable;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i == Enable) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wrData_i;
        end
    end

    assign hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lkData_o = data_q[lk_idx];

    // Byte-offset bits do not take part in indexing.
    logic unused_lo;
    assign unused_lo = ^{lkAddr_i[1:0], wrAddr_i[1:0]};

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, requests words from memory and
// hands each one to IF/ID as a single-cycle valid pulse. Handles stalls
// (hold buffer) and redirects, including redirects while a fetch is pending.
// Ports: clk_in, rst_in (async, active-high), rdy_in (0 freezes everything),
// stall_in, pcJump_in/pcTarget_in (redirect), memReq_out/memAddr_out,
// memDone_in/memData_in (memory side), instE_out/pc_out/inst_out (to IF/ID).
// Build option: define ICACHE_EN to add a direct-mapped I-cache.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W       = InstAddrW,
    parameter int INST_W       = InstW,
    parameter int STALL_W      = StallWidth,
    parameter int STALL_IF_BIT = StallIfBit,
    parameter int ICACHE_LINES = 128
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic [STALL_W-1:0] stall_in,
    input  logic               pcJump_in,
    input  logic [ADDR_W-1:0]  pcTarget_in,
    output logic               memReq_out,
    output logic [ADDR_W-1:0]  memAddr_out,
    input  logic               memDone_in,
    input  logic [INST_W-1:0]  memData_in,
    output logic               instE_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INST_W-1:0]  inst_out
);

    if_state_e         state_q,   state_d;
    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic              squash_q,  squash_d;
    logic              holdVld_q, holdVld_d;
    logic [ADDR_W-1:0] holdPc_q,  holdPc_d;
    logic [INST_W-1:0] holdInst_q, holdInst_d;
    logic              memReq_q,  memReq_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic              instE_q,   instE_d;
    logic [ADDR_W-1:0] pcOut_q,   pcOut_d;
    logic [INST_W-1:0] instOut_q, instOut_d;

    logic              stall_if;
    logic              jump;
    logic [ADDR_W-1:0] pc_inc;
    logic              ic_hit;
    logic [INST_W-1:0] ic_data;

    assign stall_if = (stall_in[STALL_IF_BIT] == Stall);
    assign jump     = (pcJump_in == Jump);
    assign pc_inc   = pc_q + ADDR_W'(PcStep);

`ifdef ICACHE_EN
    logic ic_we;

    // Every returned word is correct for memAddr_q, so squashed fetches
    // still fill their line.
    assign ic_we = rdy_in && (state_q == IF_WAIT) && memDone_in;

    if_fetch_icache #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .LINES  (ICACHE_LINES)
    ) u_icache (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .lkAddr_i (pc_q),
        .hit_o    (ic_hit),
        .lkData_o (ic_data),
        .we_i     (ic_we),
        .wrAddr_i (memAddr_q),
        .wrData_i (memData_in)
    );
`else
    assign ic_hit  = Disable;
    assign ic_data = '0;

    logic unused_cfg;
    assign unused_cfg = (ICACHE_LINES == 0);
`endif

    // Only the IF bit of the stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^stall_in;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        squash_d   = squash_q;
        holdVld_d  = holdVld_q;
        holdPc_d   = holdPc_q;
        holdInst_d = holdInst_q;
        memReq_d   = memReq_q;
        memAddr_d  = memAddr_q;
        instE_d    = Disable;
        pcOut_d    = pcOut_q;
        instOut_d  = instOut_q;

        unique case (state_q)
            IF_IDLE: begin
                if (jump) begin
                    pc_d = pcTarget_in;
                end else if (stall_if == NoStall) begin
                    if (ic_hit) begin
                        instE_d   = Enable;
                        pcOut_d   = pc_q;
                        instOut_d = ic_data;
                        pc_d      = pc_inc;
                    end else begin
                        memReq_d  = Enable;
                        memAddr_d = pc_q;
                        state_d   = IF_WAIT;
                    end
                end
            end

            IF_WAIT: begin
                if (memDone_in) begin
                    memReq_d = Disable;
                    if (squash_q || jump) begin
                        // Word belongs to an abandoned path.
                        if (jump) begin
                            pc_d = pcTarget_in;
                        end
                        squash_d = Disable;
                        state_d  = IF_IDLE;
                    end else if (stall_if == NoStall) begin
                        instE_d   = Enable;
                        pcOut_d   = pc_q;
                        instOut_d = memData_in;
                        pc_d      = pc_inc;
                        state_d   = IF_IDLE;
                    end else begin
                        holdVld_d  = Enable;
                        holdPc_d   = pc_q;
                        holdInst_d = memData_in;
                        pc_d       = pc_inc;
                        state_d    = IF_HOLD;
                    end
                end else if (jump) begin
                    // The request cannot be withdrawn; mark it stale.
                    pc_d     = pcTarget_in;
                    squash_d = Enable;
                end
            end

            IF_HOLD: begin
                if (jump) begin
                    holdVld_d = Disable;
                    pc_d      = pcTarget_in;
                    state_d   = IF_IDLE;
                end else if (stall_if == NoStall) begin
                    instE_d   = Enable;
                    pcOut_d   = holdPc_q;
                    instOut_d = holdInst_q;
                    holdVld_d = Disable;
                    state_d   = IF_IDLE;
                end
            end

            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in == rstEnable) begin
            state_q    <= IF_IDLE;
            pc_q       <= ADDR_W'(ZERO32);
            squash_q   <= Disable;
            holdVld_q  <= Disable;
            holdPc_q   <= ADDR_W'(ZERO32);
            holdInst_q <= INST_W'(ZERO32);
            memReq_q   <= Disable;
            memAddr_q  <= ADDR_W'(ZERO32);
            instE_q    <= Disable;
            pcOut_q    <= ADDR_W'(ZERO32);
            instOut_q  <= INST_W'(ZERO32);
        end else if (rdy_in) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            squash_q   <= squash_d;
            holdVld_q  <= holdVld_d;
            holdPc_q   <= holdPc_d;
            holdInst_q <= holdInst_d;
            memReq_q   <= memReq_d;
            memAddr_q  <= memAddr_d;
            instE_q    <= instE_d;
            pcOut_q    <= pcOut_d;
            instOut_q  <= instOut_d;
        end
    end

    assign memReq_out  = memReq_q;
    assign memAddr_out = memAddr_q;
    assign instE_out   = instE_q;
    assign pc_out      = pcOut_q;
    assign inst_out    = instOut_q;

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Holds the architectural fetch PC.
- Requests 32-bit instruction words from the memory controller and delivers each word to IF/ID as a valid pulse (instE_out, pc_out, inst_out).
- Honours pipeline stall and branch/jump redirect, including a redirect that arrives while a memory fetch is outstanding.

Parameters:
ADDR_W, 32, address/PC width
INST_W, 32, instruction width
STALL_W, 6, stall vector width; this stage obeys bit STALL_IF_BIT
STALL_IF_BIT, 1, index of the IF stall bit in stall_in
ICACHE_LINES, 128, I-cache entries; power of two; used only with ICACHE_EN

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  reset; asynchronous and active-high
rdy_in  in  1  global ready; 0 freezes all state
stall_in  in  STALL_W  pipeline stall vector
pcJump_in  in  1  redirect request from EX (1 = Jump)
pcTarget_in  in  ADDR_W  redirect target PC
memReq_out  out  1  fetch request to memory controller
memAddr_out  out  ADDR_W  fetch address
memDone_in  in  1  one-cycle pulse: memData_in valid
memData_in  in  INST_W  fetched word, little-endian assembled by controller
instE_out  out  1  instruction valid to IF/ID
pc_out  out  ADDR_W  PC of delivered instruction
inst_out  out  INST_W  delivered instruction

Behaviour:
- Reset (async, rst_in=1) clears the following:
  - pc = 0, state = IDLE, squash = 0, hold buffer invalid.
  - memReq_out = 0, memAddr_out = 0.
  - instE_out = 0, pc_out = 0, inst_out = 0.
  - Reset mid-WAIT abandons the request. The memory controller is reset by the same rst_in, so no late memDone_in arrives.
- rdy_in=0: no register changes, all outputs hold. Evaluation resumes on the first cycle with rdy_in=1.
- All outputs are registered. instE_out defaults to 0 every cycle and is 1 only on the cycle a word is delivered.
- FSM has three states: IDLE, WAIT, HOLD.
- IDLE:
  - pcJump_in=1: pc <= pcTarget_in; stay IDLE.
  - Else if stall_in[STALL_IF_BIT]=0: memReq_out <= 1, memAddr_out <= pc; go WAIT.
  - Else (stalled): stay IDLE and issue nothing.
- WAIT:
  - memReq_out and memAddr_out stay stable until memDone_in.
  - pcJump_in=1 in WAIT (memDone_in=0): pc <= pcTarget_in, squash <= 1; remain WAIT. The controller request cannot be aborted.
  - memDone_in=1 with squash=1, or with pcJump_in=1 the same cycle: discard the data; pc <= target if jumping; squash <= 0; memReq_out <= 0; go IDLE.
  - memDone_in=1, no squash, not stalled: instE_out <= 1, pc_out <= pc, inst_out <= memData_in; pc <= pc+4; memReq_out <= 0; go IDLE.
  - memDone_in=1, no squash, stalled: store {pc, data} in the hold buffer; pc <= pc+4; go HOLD.
- HOLD:
  - pcJump_in=1: drop the buffer; pc <= pcTarget_in; go IDLE.
  - Else if stall released: deliver the buffer (instE_out=1); go IDLE.
  - Else stay HOLD.
- Priority: rst > !rdy > jump > memDone > stall.
- pc + 4 wraps modulo 2^ADDR_W. PC bits [1:0] are never set by this block; alignment is the producer's responsibility.
- Latency: memDone_in at edge N gives instE_out high after edge N+1. Best-case throughput is one instruction per (memory latency + 2) cycles.

Optional Feature:
- Macro: ICACHE_EN.
- With ICACHE_EN: direct-mapped cache of ICACHE_LINES words.
  - Index = pc[log2(ICACHE_LINES)+1:2]; tag = remaining upper bits; one valid bit per line, cleared by reset.
  - Lookup happens in IDLE, not stalled, no jump. On a hit: deliver next edge (instE_out=1, pc <= pc+4) with no memReq_out.
  - On a miss: normal WAIT path.
  - Every memDone_in fills the line, including squashed fetches, because the data is correct for memAddr_out.
- Without ICACHE_EN: no cache storage; every fetch goes to memory.

Decomposition:
- Shared defines package holds:
  - rstEnable, Jump, Stall, NoStall, Enable, Disable, ZERO32.
  - stall vector width and IF stall bit index.
  - address and instruction ranges.
  - FSM state encodings IF_IDLE, IF_WAIT, IF_HOLD.
- One sub-module, icache: lookup port (addr -> hit, data) and fill port (we, addr, data). It is instantiated only under ICACHE_EN.

Test Plan:
- Reset, then memory returns 0x00000013 for addr 0 after 3 cycles -> memReq_out with memAddr_out=0; instE_out=1, pc_out=0, inst_out=0x13 one cycle after memDone_in; next request addr 4.
- Jump to 0x100 during WAIT for addr 8 -> data for 8 discarded with instE_out never 1; next memAddr_out=0x100.
- stall_in[1]=1 asserted in the cycle memDone_in returns 0xDEADBEEF at pc 0xC -> HOLD; after release, instE_out=1 with pc_out=0xC, inst_out=0xDEADBEEF exactly once.
- Jump to 0x40 while in HOLD -> buffered instruction dropped; next fetch addr 0x40.
- rdy_in=0 for 5 cycles mid-WAIT with memDone_in=0 -> all outputs and memAddr_out unchanged; resumes correctly.
- ICACHE_EN: loop 0x0..0xC fetched twice -> second pass shows no memReq_out and one instruction per 1 cycle with correct data.
